// File: rtl/inst_sequencer.sv
// Loop-descriptor instruction issuer for the systolic array: FIFO of descriptors, auto-incrementing addresses.
// Optional flag-wait watchdog enabled by defining SEQ_TIMEOUT_EN.
module inst_sequencer #(
    parameter int OPCODE_BITS    = 4,
    parameter int ADDR_BITS      = 8,
    parameter int INST_BITS      = OPCODE_BITS + 2 * ADDR_BITS,
    parameter int CNT_BITS       = 8,
    parameter int CYC_BITS       = 8,
    parameter int DEPTH          = 4,
    parameter int IDLE_OPCODE    = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int LVL_BITS      = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [OPCODE_BITS-1:0] desc_opcode,
    input  logic [ADDR_BITS-1:0]   desc_addra,
    input  logic [ADDR_BITS-1:0]   desc_stra,
    input  logic [ADDR_BITS-1:0]   desc_addrb,
    input  logic [ADDR_BITS-1:0]   desc_strb,
    input  logic [CNT_BITS-1:0]    desc_count,
    input  logic                   desc_flag_mode,
    input  logic [CYC_BITS-1:0]    desc_cycles,
    input  logic                   abort,
    input  logic                   flag,
    output logic [INST_BITS-1:0]   instruction,
    output logic                   busy,
    output logic                   done,
    output logic [LVL_BITS-1:0]    level,
    output logic                   err,
    output logic [1:0]             fsm_state
);
    // Handshake: a descriptor is taken at a rising edge where desc_valid && desc_ready.
    localparam int AW = $clog2(DEPTH);
    localparam logic [INST_BITS-1:0] IDLE_INST = {OPCODE_BITS'(IDLE_OPCODE), (2 * ADDR_BITS)'(0)};

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LO = 2'd1, WAIT_HI = 2'd2, WAIT_CYC = 2'd3} state_t;

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [ADDR_BITS-1:0]   addra;
        logic [ADDR_BITS-1:0]   stra;
        logic [ADDR_BITS-1:0]   addrb;
        logic [ADDR_BITS-1:0]   strb;
        logic [CNT_BITS-1:0]    count;
        logic                   flag_mode;
        logic [CYC_BITS-1:0]    cycles;
    } desc_t;

    desc_t mem [DEPTH];
    desc_t head;
    state_t state, next_state;
    logic [LVL_BITS-1:0] wr_ptr, wr_ptr_seen, rd_ptr;
    logic [OPCODE_BITS-1:0] cur_op;
    logic [ADDR_BITS-1:0] cur_addra, cur_addrb, cur_stra, cur_strb;
    logic [CNT_BITS-1:0] remaining;
    logic [CYC_BITS-1:0] hold, hold_load;
    logic push, avail, full, complete, last, pop, load, flush, timeout;
    logic [ADDR_BITS-1:0] next_addra, next_addrb;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign full       = (level == LVL_BITS'(DEPTH));
    assign push       = desc_valid && desc_ready;
    // The head becomes poppable one cycle after the entry was written.
    assign avail      = (wr_ptr_seen != rd_ptr);
    assign complete   = ((state == WAIT_HI) && flag) || ((state == WAIT_CYC) && (hold == CYC_BITS'(1)));
    assign last       = (remaining == CNT_BITS'(1));
    assign flush      = abort || timeout;
    assign pop        = !flush && avail && ((state == IDLE) || (complete && last));
    assign load       = pop && (head.count != '0);
    assign next_addra = cur_addra + cur_stra;
    assign next_addrb = cur_addrb + cur_strb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            wr_ptr_seen <= '0;
            rd_ptr      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LVL_BITS'(1);
            wr_ptr_seen <= wr_ptr;
            if (flush) rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + LVL_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{desc_opcode, desc_addra, desc_stra, desc_addrb,
                                            desc_strb, desc_count, desc_flag_mode, desc_cycles};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) next_state = IDLE;
        else if (load) next_state = head.flag_mode ? WAIT_LO : WAIT_CYC;
        else begin
            case (state)
                IDLE:     next_state = IDLE;
                WAIT_LO:  if (!flag) next_state = WAIT_HI;
                WAIT_HI:  if (flag) next_state = last ? IDLE : WAIT_LO;
                WAIT_CYC: if (complete && last) next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        level      = wr_ptr - rd_ptr;
        desc_ready = !full && !abort;
        busy       = (state != IDLE) || (level != '0);
        fsm_state  = state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instruction <= IDLE_INST;
            done        <= 1'b0;
            cur_op      <= '0;
            cur_addra   <= '0;
            cur_addrb   <= '0;
            cur_stra    <= '0;
            cur_strb    <= '0;
            remaining   <= '0;
            hold        <= '0;
            hold_load   <= '0;
        end else begin
            done <= !flush && complete && last;
            if (flush) begin
                instruction <= IDLE_INST;
            end else if (load) begin
                cur_op      <= head.opcode;
                cur_addra   <= head.addra;
                cur_addrb   <= head.addrb;
                cur_stra    <= head.stra;
                cur_strb    <= head.strb;
                remaining   <= head.count;
                hold        <= (head.cycles == '0) ? CYC_BITS'(1) : head.cycles;
                hold_load   <= (head.cycles == '0) ? CYC_BITS'(1) : head.cycles;
                instruction <= {head.opcode, head.addra, head.addrb};
            end else if (complete) begin
                remaining   <= remaining - CNT_BITS'(1);
                cur_addra   <= next_addra;
                cur_addrb   <= next_addrb;
                hold        <= hold_load;
                instruction <= last ? IDLE_INST : {cur_op, next_addra, next_addrb};
            end else if (state == WAIT_CYC) begin
                hold <= hold - CYC_BITS'(1);
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_BITS-1:0] wd;
    logic err_q, in_flag_wait, wd_restart;

    assign in_flag_wait = (state == WAIT_LO) || (state == WAIT_HI);
    assign wd_restart   = ((next_state == WAIT_LO) || (next_state == WAIT_HI)) &&
                          ((next_state != state) || load || complete);
    assign timeout      = in_flag_wait && !abort && (wd == WD_BITS'(TIMEOUT_CYCLES - 1));
    assign err          = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            if (wd_restart) wd <= '0;
            else if (in_flag_wait) wd <= wd + WD_BITS'(1);
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed testbench for inst_sequencer: flag/fixed completion, wrap, FIFO fill, abort, reset.
// The watchdog section runs only when SEQ_TIMEOUT_EN is defined.
module tb_inst_sequencer;
    localparam int IB = 20;
    localparam int LB = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [3:0]    desc_opcode = '0;
    logic [7:0]    desc_addra = '0, desc_stra = '0, desc_addrb = '0, desc_strb = '0;
    logic [7:0]    desc_count = '0, desc_cycles = '0;
    logic          desc_flag_mode = 1'b0;
    logic          abort = 1'b0;
    logic          flag = 1'b1;
    logic [IB-1:0] instruction;
    logic          busy, done, err;
    logic [LB-1:0] level;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;
    logic [IB-1:0] exp_q[$];
    logic [IB-1:0] exp_inst;

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "simulation time limit");
    end

    inst_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_opcode(desc_opcode), .desc_addra(desc_addra), .desc_stra(desc_stra),
        .desc_addrb(desc_addrb), .desc_strb(desc_strb), .desc_count(desc_count),
        .desc_flag_mode(desc_flag_mode), .desc_cycles(desc_cycles),
        .abort(abort), .flag(flag),
        .instruction(instruction), .busy(busy), .done(done),
        .level(level), .err(err), .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [3:0] op, input logic [7:0] a, input logic [7:0] sa,
                            input logic [7:0] b, input logic [7:0] sb, input logic [7:0] cnt,
                            input logic fm, input logic [7:0] cyc);
        desc_opcode    = op;
        desc_addra     = a;
        desc_stra      = sa;
        desc_addrb     = b;
        desc_strb      = sb;
        desc_count     = cnt;
        desc_flag_mode = fm;
        desc_cycles    = cyc;
    endtask

    task automatic push_one();
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_inst", instruction, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_level", level, 0);
        check("rst_err", err, 0);
        check("rst_state", fsm_state, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("rst_ready", desc_ready, 1);

        // Flag handshake, four issues with stride (1,4)
        set_desc(4'd3, 8'd0, 8'd1, 8'd0, 8'd4, 8'd4, 1'b1, 8'd0);
        push_one();
        check("lat_level", level, 1);
        check("lat_inst0", instruction, 0);
        tick();
        check("lat_inst1", instruction, 0);
        check("lat_busy", busy, 1);
        tick();
        for (int k = 0; k < 4; k++) exp_q.push_back({4'd3, 8'(k), 8'(4 * k)});
        for (int k = 0; k < 4; k++) begin
            exp_inst = exp_q.pop_front();
            check("flag_inst", instruction, exp_inst);
            check("flag_nodone", done, 0);
            tick();
            tick();
            flag = 1'b0;
            tick();
            tick();
            check("flag_hold", instruction, exp_inst);
            tick();
            flag = 1'b1;
            tick();
        end
        check("flag_done", done, 1);
        check("flag_idle", instruction, 0);
        check("flag_busy", busy, 0);
        tick();
        check("flag_pulse", done, 0);

        // Fixed-cycle completion, 3 issues of 7 cycles
        set_desc(4'd5, 8'd10, 8'd2, 8'd0, 8'd1, 8'd3, 1'b0, 8'd7);
        push_one();
        tick();
        tick();
        for (int i = 0; i < 21; i++) begin
            check("cyc_inst", instruction, {4'd5, 8'(10 + 2 * (i / 7)), 8'(i / 7)});
            check("cyc_nodone", done, 0);
            tick();
        end
        check("cyc_done", done, 1);
        check("cyc_idle", instruction, 0);

        // cycles=0 holds one cycle per issue
        set_desc(4'd6, 8'd1, 8'd1, 8'd0, 8'd0, 8'd2, 1'b0, 8'd0);
        push_one();
        tick();
        tick();
        check("cyc0_i0", instruction, {4'd6, 8'd1, 8'd0});
        tick();
        check("cyc0_i1", instruction, {4'd6, 8'd2, 8'd0});
        check("cyc0_nodone", done, 0);
        tick();
        check("cyc0_done", done, 1);
        check("cyc0_idle", instruction, 0);

        // ADDRB wrap 252 -> 0 -> 4
        set_desc(4'd7, 8'd0, 8'd0, 8'd252, 8'd4, 8'd3, 1'b0, 8'd1);
        push_one();
        tick();
        tick();
        check("wrap_0", instruction, {4'd7, 8'd0, 8'd252});
        tick();
        check("wrap_1", instruction, {4'd7, 8'd0, 8'd0});
        tick();
        check("wrap_2", instruction, {4'd7, 8'd0, 8'd4});
        tick();
        check("wrap_done", done, 1);

        // Fill the FIFO behind a running descriptor; back-to-back issue and count=0 skip
        set_desc(4'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 1'b0, 8'd20);
        push_one();
        tick();
        tick();
        check("fill_d1", instruction, {4'd1, 8'd0, 8'd0});
        check("fill_lvl0", level, 0);
        desc_valid = 1'b1;
        set_desc(4'd2, 8'd5, 8'd0, 8'd6, 8'd0, 8'd1, 1'b0, 8'd3);
        tick();
        set_desc(4'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd5);
        tick();
        set_desc(4'd4, 8'd7, 8'd0, 8'd8, 8'd0, 8'd1, 1'b0, 8'd2);
        tick();
        set_desc(4'd8, 8'd9, 8'd0, 8'd10, 8'd0, 8'd1, 1'b0, 8'd1);
        tick();
        check("full_level", level, 4);
        check("full_ready", desc_ready, 0);
        set_desc(4'd9, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 1'b0, 8'd1);
        tick();
        desc_valid = 1'b0;
        check("full_nopush", level, 4);
        repeat (15) tick();
        check("fill_d1b", instruction, {4'd1, 8'd1, 8'd0});
        repeat (20) tick();
        check("b2b_inst", instruction, {4'd2, 8'd5, 8'd6});
        check("b2b_done", done, 1);
        check("b2b_level", level, 3);
        tick();
        check("b2b_pulse", done, 0);
        tick();
        tick();
        check("d2_done", done, 1);
        check("skip_idle", instruction, 0);
        check("skip_level", level, 2);
        tick();
        check("d4_inst", instruction, {4'd4, 8'd7, 8'd8});
        check("skip_nodone", done, 0);
        check("d4_level", level, 1);
        tick();
        check("d4_wait", done, 0);
        tick();
        check("d4_done", done, 1);
        check("d5_inst", instruction, {4'd8, 8'd9, 8'd10});
        tick();
        check("d5_done", done, 1);
        check("d5_idle", instruction, 0);
        check("d5_busy", busy, 0);

        // Abort during WAIT_HI with two queued descriptors and a push offered
        set_desc(4'd3, 8'd1, 8'd0, 8'd2, 8'd0, 8'd1, 1'b1, 8'd0);
        desc_valid = 1'b1;
        tick();
        set_desc(4'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 1'b0, 8'd4);
        tick();
        tick();
        desc_valid = 1'b0;
        flag = 1'b0;
        check("abt_level", level, 2);
        check("abt_inst", instruction, {4'd3, 8'd1, 8'd2});
        tick();
        tick();
        check("abt_state", fsm_state, 2);
        set_desc(4'd6, 8'd3, 8'd0, 8'd3, 8'd0, 8'd1, 1'b0, 8'd1);
        abort = 1'b1;
        desc_valid = 1'b1;
        flag = 1'b1;
        #1;
        check("abt_ready", desc_ready, 0);
        tick();
        abort = 1'b0;
        desc_valid = 1'b0;
        check("abt_flush", level, 0);
        check("abt_idle", instruction, 0);
        check("abt_busy", busy, 0);
        check("abt_nodone", done, 0);
        tick();
        check("abt_drop", level, 0);
        check("abt_nodone2", done, 0);

        // Async reset during WAIT_CYC
        set_desc(4'd5, 8'd3, 8'd0, 8'd4, 8'd0, 8'd2, 1'b0, 8'd10);
        push_one();
        set_desc(4'd6, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 1'b0, 8'd1);
        push_one();
        tick();
        repeat (3) tick();
        check("ar_state", fsm_state, 3);
        check("ar_level", level, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_inst", instruction, 0);
        check("ar_busy", busy, 0);
        check("ar_level0", level, 0);
        check("ar_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("ar_ready", desc_ready, 1);
        check("ar_stay", instruction, 0);

`ifdef SEQ_TIMEOUT_EN
        set_desc(4'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 1'b1, 8'd0);
        flag = 1'b1;
        push_one();
        tick();
        tick();
        repeat (15) tick();
        check("to_pre", err, 0);
        check("to_busy", busy, 1);
        tick();
        check("to_err", err, 1);
        check("to_idle", instruction, 0);
        check("to_flushed", busy, 0);
        repeat (5) tick();
        check("to_sticky", err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
